lb_arbiter: RTL and testbench
=============================

# lb_arbiter

Two-master round-robin arbiter for the 32-bit local bus, letting the USB3 MesaBus bridge and a second master (UART MesaBus bridge or on-chip sequencer) share one slave-side local bus. It accepts single-cycle write and read strobes from each master into a one-deep pending buffer per master. It issues one transaction at a time on the shared bus and waits for read completion. Each read response is routed back to the master that issued it.

## Interface
- TIMEOUT_CYC, 1024: read-wait cycles before forced completion (only with timeout compiled in); 2..65535.
- TIMEOUT_DATA, 32'hDEADBEEF: read data returned on timeout.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- m0_wr, m0_rd  in  1 each  master 0 single-cycle write/read strobes.
- m0_addr  in  32  master 0 address, valid with strobe.
- m0_wr_d  in  32  master 0 write data, valid with m0_wr.
- m0_busy  out  1  master 0 request pending or in flight.
- m0_rd_rdy  out  1  master 0 read-data strobe, one cycle.
- m0_rd_d  out  32  master 0 read data, valid with m0_rd_rdy.
- m1_*: identical set for master 1.
- lb_wr, lb_rd  out  1 each  shared-bus strobes, one cycle.
- lb_addr, lb_wr_d  out  32 each  shared-bus address/data; hold the last issued values.
- lb_rd_rdy  in  1  slave read-complete strobe.
- lb_rd_d  in  32  slave read data, valid with lb_rd_rdy.
- ovfl  out  2  sticky per-master overflow flags.
- rd_timeout  out  1  sticky read-timeout flag.

## Operation
- Reset values:
  - All strobes, busy, ovfl and rd_timeout are 0.
  - All data and address outputs are 0.
  - State is IDLE, last_grant=1, so master 0 wins first.
- Request capture (per master):
  - A strobe while pending is empty latches op, addr and wr_d; pending is set on the next edge.
  - A strobe while pending is full, or while busy=1, is dropped and sets ovfl[n].
  - m_wr and m_rd asserted together: the write is captured, the read is dropped, and ovfl[n] is set.
- FSM states: IDLE, WR, RD_WAIT.
- IDLE:
  - If any pending, grant one master. With both pending, grant the master ≠ last_grant. Update last_grant.
  - Register lb_addr/lb_wr_d from the granted buffer.
  - Write: pulse lb_wr and go to WR. Read: pulse lb_rd and go to RD_WAIT.
- WR: clear the granted master's pending, then return to IDLE.
- RD_WAIT:
  - lb_rd_rdy is accepted in any RD_WAIT cycle, including the lb_rd cycle.
  - On accept, register mN_rd_d=lb_rd_d and pulse mN_rd_rdy for the granted master only.
  - Clear that master's pending and return to IDLE.
- lb_rd_rdy outside RD_WAIT is ignored.
- busy: set the cycle after capture; clears the cycle WR is exited, or with the mN_rd_rdy pulse.
- Reset mid-transaction: pending and in-flight requests are lost, no response is generated, and outputs return to reset values immediately.

## Timing
- Request strobe at cycle 0 → pending at cycle 1 → lb strobe at cycle 2 (idle bus, no contention).
- Back-to-back writes from alternating masters: one lb_wr every 2 cycles.
- Read response: lb_rd_rdy at cycle k → mN_rd_rdy at cycle k+1.
- The losing master waits for the full completion of the winner's transaction plus 1 cycle.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- LB_ARB_TIMEOUT_EN defined:
  - A 16-bit counter runs in RD_WAIT. When TIMEOUT_CYC cycles pass without lb_rd_rdy, the arbiter completes the read with TIMEOUT_DATA, pulses mN_rd_rdy, sets rd_timeout and returns to IDLE.
  - A late lb_rd_rdy after timeout is ignored.
- Undefined: RD_WAIT waits indefinitely, and rd_timeout is tied 0.

## Structure
- Package lb_arb_pkg:
  - State encodings (IDLE/WR/RD_WAIT).
  - Opcode constants (OP_WR, OP_RD).
  - Default TIMEOUT_DATA.
- Sub-module lb_arb_req_buf: per-master one-deep capture buffer with pending/ovfl logic. Instantiated twice.
- Grant, FSM, timeout counter and response routing live in lb_arbiter.

## Test plan
- m0_wr addr=0x10 data=0x1234 at cycle 0 → lb_wr at cycle 2 with lb_addr=0x10, lb_wr_d=0x1234; m0_busy high cycles 1–2.
- m0_rd and m1_rd in the same cycle, slave replies 3 cycles after each lb_rd with data=addr → m0 served first, then m1; each mN_rd_rdy carries its own address; no rd_rdy on the other master.
- m1_wr twice on consecutive cycles → first write issued, second dropped, ovfl=2'b10, exactly one lb_wr.
- Continuous requests from both masters for 8 transactions → grants alternate 0,1,0,1,…; no master is granted twice in a row while the other is pending.
- With LB_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, m0_rd with a silent slave → m0_rd_rdy with 0xDEADBEEF 16–17 cycles after lb_rd; rd_timeout=1; a late lb_rd_rdy is ignored.
- Reset asserted during RD_WAIT → all outputs 0 asynchronously; after release, a new m1_wr issues normally with m0 priority restored.

Source files
------------

// File: rtl/lb_arb_pkg.sv
// Shared types and constants for the two-master local-bus round-robin arbiter.
package lb_arb_pkg;
  localparam int NUM_M = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  localparam logic OP_WR = 1'b0;
  localparam logic OP_RD = 1'b1;

  localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEADBEEF;

  typedef struct packed {
    logic        op;
    logic [31:0] addr;
    logic [31:0] wr_d;
  } req_t;
endpackage

// File: rtl/lb_arb_req_buf.sv
// One-deep request capture buffer for a single master; flags dropped strobes.
module lb_arb_req_buf
  import lb_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic        rd,
  input  logic [31:0] addr,
  input  logic [31:0] wr_d,
  input  logic        clr,
  output logic        pending,
  output req_t        req,
  output logic        ovfl
);
  logic strb;
  assign strb = wr | rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      req     <= '0;
      ovfl    <= 1'b0;
    end else begin
      if (clr)
        pending <= 1'b0;
      else if (strb && !pending) begin
        pending  <= 1'b1;
        req.op   <= wr ? OP_WR : OP_RD;
        req.addr <= addr;
        req.wr_d <= wr_d;
      end
      // wr+rd together keeps the write and loses the read
      if ((strb && pending) || (wr && rd))
        ovfl <= 1'b1;
    end
  end
endmodule

// File: rtl/lb_arbiter.sv
// Two-master round-robin local-bus arbiter with read-response routing.
// Optional read timeout compiled in with LB_ARB_TIMEOUT_EN.
module lb_arbiter
  import lb_arb_pkg::*;
#(
  parameter int unsigned  TIMEOUT_CYC  = 1024,
  parameter logic [31:0]  TIMEOUT_DATA = TIMEOUT_DATA_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_wr,
  input  logic        m0_rd,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wr_d,
  output logic        m0_busy,
  output logic        m0_rd_rdy,
  output logic [31:0] m0_rd_d,
  input  logic        m1_wr,
  input  logic        m1_rd,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wr_d,
  output logic        m1_busy,
  output logic        m1_rd_rdy,
  output logic [31:0] m1_rd_d,
  output logic        lb_wr,
  output logic        lb_rd,
  output logic [31:0] lb_addr,
  output logic [31:0] lb_wr_d,
  input  logic        lb_rd_rdy,
  input  logic [31:0] lb_rd_d,
  output logic [1:0]  ovfl,
  output logic        rd_timeout
);
  logic [NUM_M-1:0]        wr_in, rd_in, pend, clr, rd_rdy;
  logic [NUM_M-1:0][31:0]  addr_in, wr_d_in, rd_d;
  req_t [NUM_M-1:0]        req;

  assign wr_in   = {m1_wr, m0_wr};
  assign rd_in   = {m1_rd, m0_rd};
  assign addr_in = {m1_addr, m0_addr};
  assign wr_d_in = {m1_wr_d, m0_wr_d};

  for (genvar g = 0; g < NUM_M; g++) begin : g_buf
    lb_arb_req_buf u_buf (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr_in[g]),
      .rd      (rd_in[g]),
      .addr    (addr_in[g]),
      .wr_d    (wr_d_in[g]),
      .clr     (clr[g]),
      .pending (pend[g]),
      .req     (req[g]),
      .ovfl    (ovfl[g])
    );
  end

  assign m0_busy   = pend[0];
  assign m1_busy   = pend[1];
  assign m0_rd_rdy = rd_rdy[0];
  assign m1_rd_rdy = rd_rdy[1];
  assign m0_rd_d   = rd_d[0];
  assign m1_rd_d   = rd_d[1];

  state_t state;
  logic   gnt, last_gnt, nxt_gnt, done, to_hit;

  always_comb begin
    nxt_gnt = (&pend) ? ~last_gnt : pend[1];
    done    = (state == RD_WAIT) && (lb_rd_rdy || to_hit);
    clr     = '0;
    if (state == WR || done)
      clr[gnt] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      lb_wr    <= 1'b0;
      lb_rd    <= 1'b0;
      lb_addr  <= '0;
      lb_wr_d  <= '0;
      rd_rdy   <= '0;
      rd_d     <= '0;
    end else begin
      lb_wr  <= 1'b0;
      lb_rd  <= 1'b0;
      rd_rdy <= '0;
      case (state)
        IDLE: if (|pend) begin
          gnt      <= nxt_gnt;
          last_gnt <= nxt_gnt;
          lb_addr  <= req[nxt_gnt].addr;
          lb_wr_d  <= req[nxt_gnt].wr_d;
          if (req[nxt_gnt].op == OP_WR) begin
            lb_wr <= 1'b1;
            state <= WR;
          end else begin
            lb_rd <= 1'b1;
            state <= RD_WAIT;
          end
        end
        WR: state <= IDLE;
        RD_WAIT: if (done) begin
          rd_rdy[gnt] <= 1'b1;
          rd_d[gnt]   <= to_hit ? TIMEOUT_DATA : lb_rd_d;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LB_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;
  // a real response in the final cycle still wins over the timeout
  assign to_hit = (state == RD_WAIT) && !lb_rd_rdy &&
                  (to_cnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt     <= '0;
      rd_timeout <= 1'b0;
    end else begin
      to_cnt     <= (state == RD_WAIT && !done) ? to_cnt + 16'd1 : 16'd0;
      rd_timeout <= rd_timeout | to_hit;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYC;
  assign to_hit     = 1'b0;
  assign rd_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_lb_arbiter.sv
// Directed self-checking bench for lb_arbiter (inputs driven and outputs sampled 1ns after posedge).
module tb_lb_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic        m0_wr = 0, m0_rd = 0, m1_wr = 0, m1_rd = 0;
  logic [31:0] m0_addr = 0, m0_wr_d = 0, m1_addr = 0, m1_wr_d = 0;
  logic        m0_busy, m0_rd_rdy, m1_busy, m1_rd_rdy;
  logic [31:0] m0_rd_d, m1_rd_d;
  logic        lb_wr, lb_rd, lb_rd_rdy = 0, rd_timeout;
  logic [31:0] lb_addr, lb_wr_d, lb_rd_d = 0;
  logic [1:0]  ovfl;
  int          ntests = 0, nfail = 0;

  lb_arbiter #(.TIMEOUT_CYC(16), .TIMEOUT_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .reset(reset),
    .m0_wr(m0_wr), .m0_rd(m0_rd), .m0_addr(m0_addr), .m0_wr_d(m0_wr_d),
    .m0_busy(m0_busy), .m0_rd_rdy(m0_rd_rdy), .m0_rd_d(m0_rd_d),
    .m1_wr(m1_wr), .m1_rd(m1_rd), .m1_addr(m1_addr), .m1_wr_d(m1_wr_d),
    .m1_busy(m1_busy), .m1_rd_rdy(m1_rd_rdy), .m1_rd_d(m1_rd_d),
    .lb_wr(lb_wr), .lb_rd(lb_rd), .lb_addr(lb_addr), .lb_wr_d(lb_wr_d),
    .lb_rd_rdy(lb_rd_rdy), .lb_rd_d(lb_rd_d),
    .ovfl(ovfl), .rd_timeout(rd_timeout)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int ng, t, last_t;
    // reset state
    #2;
    chk("rst_strobes", {lb_wr, lb_rd, m0_rd_rdy, m1_rd_rdy, m0_busy, m1_busy}, 0);
    chk("rst_data", {lb_addr, lb_wr_d}, 0);
    chk("rst_rd_d", {m0_rd_d, m1_rd_d}, 0);
    chk("rst_flags", {ovfl, rd_timeout}, 0);
    cyc(); cyc();
    reset = 0;
    cyc();

    // simultaneous reads: m0 first, then m1; slave replies 3 cycles after lb_rd
    m0_rd = 1; m0_addr = 32'h100; m1_rd = 1; m1_addr = 32'h200;
    cyc(); m0_rd = 0; m1_rd = 0;
    chk("rd_busy_c1", {m1_busy, m0_busy}, 2'b11);
    chk("rd_no_strobe_c1", lb_rd, 0);
    cyc();
    chk("rd0_lb_rd", lb_rd, 1);
    chk("rd0_lb_addr", lb_addr, 32'h100);
    cyc(); cyc(); cyc();
    lb_rd_rdy = 1; lb_rd_d = 32'h100;
    cyc(); lb_rd_rdy = 0;
    chk("rd0_rdy", {m1_rd_rdy, m0_rd_rdy}, 2'b01);
    chk("rd0_data", m0_rd_d, 32'h100);
    chk("rd0_busy", {m1_busy, m0_busy}, 2'b10);
    cyc();
    chk("rd1_lb_rd", lb_rd, 1);
    chk("rd1_lb_addr", lb_addr, 32'h200);
    chk("rd1_m0_quiet", m0_rd_rdy, 0);
    cyc(); cyc(); cyc();
    lb_rd_rdy = 1; lb_rd_d = 32'h200;
    cyc(); lb_rd_rdy = 0;
    chk("rd1_rdy", {m1_rd_rdy, m0_rd_rdy}, 2'b10);
    chk("rd1_data", m1_rd_d, 32'h200);
    chk("rd1_busy", m1_busy, 0);
    chk("rd_no_ovfl", ovfl, 2'b00);

    // single write latency
    m0_wr = 1; m0_addr = 32'h10; m0_wr_d = 32'h1234;
    cyc(); m0_wr = 0;
    chk("wr_busy_c1", m0_busy, 1);
    chk("wr_lb_wr_c1", lb_wr, 0);
    cyc();
    chk("wr_lb_wr_c2", lb_wr, 1);
    chk("wr_lb_addr", lb_addr, 32'h10);
    chk("wr_lb_wr_d", lb_wr_d, 32'h1234);
    chk("wr_busy_c2", m0_busy, 1);
    cyc();
    chk("wr_lb_wr_c3", lb_wr, 0);
    chk("wr_busy_c3", m0_busy, 0);

    // back-to-back m1 writes: second dropped
    m1_wr = 1; m1_addr = 32'h20; m1_wr_d = 32'hAA;
    cyc(); m1_addr = 32'h24; m1_wr_d = 32'hBB;
    cyc(); m1_wr = 0;
    chk("ovf_lb_wr", lb_wr, 1);
    chk("ovf_lb_addr", lb_addr, 32'h20);
    chk("ovf_lb_wr_d", lb_wr_d, 32'hAA);
    chk("ovf_flag", ovfl, 2'b10);
    cyc();
    chk("ovf_no_2nd_c3", lb_wr, 0);
    cyc();
    chk("ovf_no_2nd_c4", lb_wr, 0);
    chk("ovf_hold_addr", lb_addr, 32'h20);
    chk("ovf_busy", m1_busy, 0);

    // continuous traffic from both masters: grants alternate every 2 cycles
    m0_wr = 1; m0_addr = 32'h1000; m1_wr = 1; m1_addr = 32'h2000;
    ng = 0; t = 0; last_t = 0;
    while (ng < 8 && t < 40) begin
      cyc(); t++;
      if (lb_wr) begin
        chk("rr_master", lb_addr[15:12], (ng % 2 == 0) ? 4'h1 : 4'h2);
        if (ng > 0) chk("rr_spacing", t - last_t, 2);
        last_t = t;
        ng++;
      end
      m0_wr = !m0_busy;
      m1_wr = !m1_busy;
    end
    m0_wr = 0; m1_wr = 0;
    chk("rr_count", ng, 8);
    repeat (6) cyc();
    chk("rr_drained", {m1_busy, m0_busy}, 2'b00);
    chk("rr_no_ovfl", ovfl, 2'b10);

    // read with a silent slave
    m0_rd = 1; m0_addr = 32'h300;
    cyc(); m0_rd = 0;
    cyc();
    chk("to_lb_rd", lb_rd, 1);
    repeat (15) cyc();
    chk("to_c17_quiet", m0_rd_rdy, 0);
    cyc();
`ifdef LB_ARB_TIMEOUT_EN
    chk("to_c18_rdy", m0_rd_rdy, 1);
    chk("to_c18_data", m0_rd_d, 32'hDEADBEEF);
    chk("to_flag", rd_timeout, 1);
`else
    chk("to_c18_wait", {m0_rd_rdy, m0_busy}, 2'b01);
    chk("to_flag", rd_timeout, 0);
`endif
    cyc();
    lb_rd_rdy = 1; lb_rd_d = 32'h5555;
    cyc(); lb_rd_rdy = 0;
`ifdef LB_ARB_TIMEOUT_EN
    chk("to_late_ignored", {m1_rd_rdy, m0_rd_rdy}, 2'b00);
    chk("to_late_data", m0_rd_d, 32'hDEADBEEF);
`else
    chk("to_late_rdy", {m1_rd_rdy, m0_rd_rdy}, 2'b01);
    chk("to_late_data", m0_rd_d, 32'h5555);
`endif
    cyc();

    // asynchronous reset during RD_WAIT
    m1_rd = 1; m1_addr = 32'h400;
    cyc(); m1_rd = 0;
    cyc();
    chk("ar_lb_rd", lb_rd, 1);
    cyc();
    reset = 1;
    #1;
    chk("ar_strobes", {lb_wr, lb_rd, m0_rd_rdy, m1_rd_rdy, m0_busy, m1_busy}, 0);
    chk("ar_data", {lb_addr, lb_wr_d}, 0);
    chk("ar_rd_d", {m0_rd_d, m1_rd_d}, 0);
    chk("ar_flags", {ovfl, rd_timeout}, 0);
    cyc();
    reset = 0;
    cyc();
    m0_wr = 1; m0_addr = 32'h60; m0_wr_d = 32'h1;
    m1_wr = 1; m1_addr = 32'h64; m1_wr_d = 32'h2;
    cyc(); m0_wr = 0; m1_wr = 0;
    cyc();
    chk("ar_m0_first", {31'd0, lb_wr, lb_addr}, {31'd0, 1'b1, 32'h60});
    cyc(); cyc();
    chk("ar_m1_second", {31'd0, lb_wr, lb_addr}, {31'd0, 1'b1, 32'h64});
    chk("ar_m1_wr_d", lb_wr_d, 32'h2);
    chk("ar_no_lost_resp", m1_rd_rdy, 0);
    cyc();

    // wr and rd together: write kept, read dropped
    m0_wr = 1; m0_rd = 1; m0_addr = 32'h70; m0_wr_d = 32'h7;
    cyc(); m0_wr = 0; m0_rd = 0;
    cyc();
    chk("wrrd_strobes", {lb_wr, lb_rd}, 2'b10);
    chk("wrrd_addr", lb_addr, 32'h70);
    chk("wrrd_ovfl", ovfl, 2'b01);
    cyc();
    // stray lb_rd_rdy outside RD_WAIT
    lb_rd_rdy = 1; lb_rd_d = 32'h9999;
    cyc(); lb_rd_rdy = 0;
    chk("idle_rdy_ignored", {m1_rd_rdy, m0_rd_rdy}, 2'b00);
    chk("idle_rd_d_hold", m0_rd_d, 32'h0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
